// File: rtl/adc_scan_seq.sv
// ----------------------------------------------------------------------------
// adc_scan_seq
//   Scan sequencer sitting in front of the ADC128S022 serial driver. A trigger
//   converts every channel enabled in ch_mask, lowest index first, one
//   request/response handshake per channel. Each raw sample has a per-channel
//   offset subtracted and the signed result is streamed out and also kept in
//   an 8-entry bank that can be read combinationally.
//
// Ports
//   clk, rstn                   system clock, synchronous active-low reset
//   trig, ch_mask               scan start pulse and channel enable mask
//   offset_wr/_sel/_val         offset bank write port (any state)
//   adc_wr, adc_channel         conversion request to the driver
//   adc_data, adc_rdy           driver result and done pulse
//   res_data, res_ch, res_valid signed result stream
//   scan_done, busy, ovr        scan status; ovr = trig dropped while busy
//   timeout_err                 driver did not answer, scan aborted
//   rd_sel, rd_data             result bank read port
// ----------------------------------------------------------------------------
module adc_scan_seq #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd2048
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        trig,
    input  logic [7:0]  ch_mask,
    input  logic        offset_wr,
    input  logic [2:0]  offset_sel,
    input  logic [11:0] offset_val,
    output logic        adc_wr,
    output logic [2:0]  adc_channel,
    input  logic [11:0] adc_data,
    input  logic        adc_rdy,
    output logic [12:0] res_data,
    output logic [2:0]  res_ch,
    output logic        res_valid,
    output logic        scan_done,
    output logic        busy,
    output logic        ovr,
    output logic        timeout_err,
    input  logic [2:0]  rd_sel,
    output logic [12:0] rd_data
);

    // state | meaning
    // IDLE  | waiting for trig
    // SCAN  | pick next masked channel and issue request, or finish scan
    // WAIT  | conversion outstanding, waiting for adc_rdy or timeout
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state_q;
    logic [7:0]  mask_q;
    logic [15:0] timer_q;
    logic [11:0] offset_q [8];
    logic [12:0] result_q [8];

    logic        adc_wr_q;
    logic [2:0]  adc_channel_q;
    logic [12:0] res_data_q;
    logic [2:0]  res_ch_q;
    logic        res_valid_q;
    logic        scan_done_q;
    logic        busy_q;
    logic        ovr_q;
    logic        timeout_err_q;

    logic [2:0]  idx_d;
    logic [12:0] diff_d;

    // Lowest set bit of the remaining mask wins.
    always_comb begin
        idx_d = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i]) idx_d = 3'(i);
        end
    end

    // Reads the offset before any same-cycle offset write lands, so a write to
    // the converting channel only takes effect on its next conversion.
    assign diff_d = {1'b0, adc_data} - {1'b0, offset_q[adc_channel_q]};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= IDLE;
            mask_q        <= 8'd0;
            timer_q       <= 16'd0;
            adc_wr_q      <= 1'b0;
            adc_channel_q <= 3'd0;
            res_data_q    <= 13'd0;
            res_ch_q      <= 3'd0;
            res_valid_q   <= 1'b0;
            scan_done_q   <= 1'b0;
            busy_q        <= 1'b0;
            ovr_q         <= 1'b0;
            timeout_err_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                offset_q[i] <= 12'd0;
                result_q[i] <= 13'd0;
            end
        end else begin
            adc_wr_q      <= 1'b0;
            res_valid_q   <= 1'b0;
            scan_done_q   <= 1'b0;
            ovr_q         <= 1'b0;
            timeout_err_q <= 1'b0;

            if (offset_wr) offset_q[offset_sel] <= offset_val;

            case (state_q)
                IDLE: begin
                    if (trig) begin
                        mask_q  <= ch_mask;
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (trig) ovr_q <= 1'b1;
                    if (mask_q == 8'd0) begin
                        scan_done_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        adc_channel_q <= idx_d;
                        adc_wr_q      <= 1'b1;
                        mask_q[idx_d] <= 1'b0;
                        // Down-counter: terminal count 0 is reached on the
                        // TIMEOUT_CYC-th WAIT cycle.
                        timer_q       <= TIMEOUT_CYC - 16'd1;
                        state_q       <= WAIT;
                    end
                end
                WAIT: begin
                    if (trig) ovr_q <= 1'b1;
                    if (adc_rdy) begin
                        res_data_q              <= diff_d;
                        res_ch_q                <= adc_channel_q;
                        res_valid_q             <= 1'b1;
                        result_q[adc_channel_q] <= diff_d;
                        state_q                 <= SCAN;
                    end else if (timer_q == 16'd0) begin
                        timeout_err_q <= 1'b1;
                        mask_q        <= 8'd0;
                        busy_q        <= 1'b0;
                        state_q       <= IDLE;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign adc_wr      = adc_wr_q;
    assign adc_channel = adc_channel_q;
    assign res_data    = res_data_q;
    assign res_ch      = res_ch_q;
    assign res_valid   = res_valid_q;
    assign scan_done   = scan_done_q;
    assign busy        = busy_q;
    assign ovr         = ovr_q;
    assign timeout_err = timeout_err_q;
    assign rd_data     = result_q[rd_sel];

endmodule

// File: tb/tb_adc_scan_seq.sv
// ----------------------------------------------------------------------------
// tb_adc_scan_seq
//   Drives adc_scan_seq with a simple ADC driver model (random response
//   latency, per-channel data table) and compares the result stream, request
//   order, status pulses and result bank against a list-based model built
//   from the channel mask and the offset table.
// ----------------------------------------------------------------------------
module tb_adc_scan_seq;

    localparam logic [15:0] TMO = 16'd64;

    logic        clk;
    logic        rstn;
    logic        trig;
    logic [7:0]  ch_mask;
    logic        offset_wr;
    logic [2:0]  offset_sel;
    logic [11:0] offset_val;
    logic        adc_wr;
    logic [2:0]  adc_channel;
    logic [11:0] adc_data;
    logic        adc_rdy;
    logic [12:0] res_data;
    logic [2:0]  res_ch;
    logic        res_valid;
    logic        scan_done;
    logic        busy;
    logic        ovr;
    logic        timeout_err;
    logic [2:0]  rd_sel;
    logic [12:0] rd_data;

    int n_chk = 0;
    int n_err = 0;

    logic [11:0] off_model [8];
    logic [11:0] drv_data  [8];
    logic [12:0] res_model [8];
    bit          drv_mute;
    bit          race_en;
    logic [2:0]  race_ch;
    logic [11:0] race_val;

    adc_scan_seq #(.TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .trig        (trig),
        .ch_mask     (ch_mask),
        .offset_wr   (offset_wr),
        .offset_sel  (offset_sel),
        .offset_val  (offset_val),
        .adc_wr      (adc_wr),
        .adc_channel (adc_channel),
        .adc_data    (adc_data),
        .adc_rdy     (adc_rdy),
        .res_data    (res_data),
        .res_ch      (res_ch),
        .res_valid   (res_valid),
        .scan_done   (scan_done),
        .busy        (busy),
        .ovr         (ovr),
        .timeout_err (timeout_err),
        .rd_sel      (rd_sel),
        .rd_data     (rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_chk, n_err);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ADC driver model: answers each request after 1..5 cycles with the
    // table value for that channel; optionally writes that channel's offset
    // in the very cycle it returns rdy.
    initial begin
        adc_rdy  = 1'b0;
        adc_data = 12'd0;
        forever begin
            @(negedge clk);
            if (adc_wr === 1'b1 && !drv_mute) begin
                automatic logic [2:0] ch = adc_channel;
                automatic int lat = $urandom_range(1, 5);
                repeat (lat - 1) @(negedge clk);
                if (!drv_mute && rstn) begin
                    adc_rdy  = 1'b1;
                    adc_data = drv_data[ch];
                    if (race_en && ch == race_ch) begin
                        offset_wr  = 1'b1;
                        offset_sel = ch;
                        offset_val = race_val;
                    end
                    @(negedge clk);
                    adc_rdy   = 1'b0;
                    adc_data  = 12'($urandom);
                    offset_wr = 1'b0;
                end
            end
        end
    end

    task automatic write_off(input logic [2:0] sel, input logic [11:0] val);
        @(negedge clk);
        offset_wr  = 1'b1;
        offset_sel = sel;
        offset_val = val;
        @(negedge clk);
        offset_wr     = 1'b0;
        off_model[sel] = val;
    endtask

    task automatic check_bank();
        for (int i = 0; i < 8; i++) begin
            rd_sel = 3'(i);
            #1;
            chk("rd_bank", rd_data, res_model[i]);
        end
    endtask

    // One scan with the driver answering. ovr_idx >= 0 raises trig once
    // while the request with that ordinal is outstanding.
    task automatic run_scan(input logic [7:0] mask, input int ovr_idx);
        int          exp_ch[$];
        logic [12:0] exp_res[$];
        int n_wr = 0, n_res = 0, n_done = 0, n_ovr = 0, n_busy = 0;
        int cyc = 0, last_res = 0;
        bit done = 0;
        for (int c = 0; c < 8; c++) begin
            if (mask[c]) begin
                exp_ch.push_back(c);
                exp_res.push_back(13'(int'(drv_data[c]) - int'(off_model[c])));
            end
        end
        @(negedge clk);
        trig    = 1'b1;
        ch_mask = mask;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            trig    = 1'b0;
            ch_mask = 8'($urandom);
            if (busy) n_busy++;
            if (ovr) n_ovr++;
            if (timeout_err) chk("unexpected_timeout", 1, 0);
            if (adc_wr) begin
                if (n_wr == 0) chk("wr_latency", cyc, 2);
                else chk("wr_gap", cyc - last_res, 1);
                chk("no_rearm", n_wr, n_res);
                if (n_wr < exp_ch.size()) chk("wr_channel", adc_channel, exp_ch[n_wr]);
                else chk("extra_wr", n_wr, exp_ch.size());
                if (n_wr == ovr_idx) trig = 1'b1;
                n_wr++;
            end
            if (res_valid) begin
                if (n_res < exp_ch.size()) begin
                    chk("res_ch", res_ch, exp_ch[n_res]);
                    chk("res_data", res_data, exp_res[n_res]);
                    res_model[exp_ch[n_res]] = exp_res[n_res];
                end else begin
                    chk("extra_res", n_res, exp_ch.size());
                end
                last_res = cyc;
                n_res++;
            end
            if (scan_done) begin
                n_done++;
                done = 1;
                if (mask == 8'd0) chk("empty_done_latency", cyc, 2);
                else chk("done_latency", cyc - last_res, 1);
                chk("busy_at_done", busy, 0);
            end
        end
        if (!done) chk("scan_done_timeout", 0, 1);
        repeat (3) begin
            @(negedge clk);
            ch_mask = 8'($urandom);
            if (scan_done) n_done++;
            if (adc_wr) n_wr++;
            if (ovr) n_ovr++;
        end
        chk("wr_count", n_wr, exp_ch.size());
        chk("res_count", n_res, exp_ch.size());
        chk("done_count", n_done, 1);
        chk("ovr_count", n_ovr, (ovr_idx >= 0 && ovr_idx < exp_ch.size()) ? 1 : 0);
        chk("busy_idle", busy, 0);
        if (mask == 8'd0) chk("empty_busy_cycles", n_busy, 1);
        check_bank();
    endtask

    task automatic check_outputs_zero();
        chk("rst_adc_wr", adc_wr, 0);
        chk("rst_adc_channel", adc_channel, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_ch", res_ch, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_scan_done", scan_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_timeout", timeout_err, 0);
    endtask

    initial begin
        int cnt;
        int extra;
        rstn       = 1'b0;
        trig       = 1'b0;
        ch_mask    = 8'd0;
        offset_wr  = 1'b0;
        offset_sel = 3'd0;
        offset_val = 12'd0;
        rd_sel     = 3'd0;
        drv_mute   = 1'b0;
        race_en    = 1'b0;
        race_ch    = 3'd0;
        race_val   = 12'd0;
        for (int i = 0; i < 8; i++) begin
            off_model[i] = 12'd0;
            res_model[i] = 13'd0;
            drv_data[i]  = 12'd0;
        end

        repeat (3) @(negedge clk);
        check_outputs_zero();
        rstn = 1'b1;
        check_bank();

        // Two-channel scan, zero offsets.
        drv_data[0] = 12'hABC;
        drv_data[2] = 12'h123;
        run_scan(8'h05, -1);
        rd_sel = 3'd0; #1;
        chk("t1_rd_ch0", rd_data, 13'h0ABC);
        rd_sel = 3'd2; #1;
        chk("t1_rd_ch2", rd_data, 13'h0123);

        // Negative result: 50 - 100.
        write_off(3'd1, 12'd100);
        drv_data[1] = 12'd50;
        run_scan(8'h02, -1);
        rd_sel = 3'd1; #1;
        chk("t2_rd_ch1", rd_data, 13'h1FCE);

        // Full mask with a trigger during channel 3's conversion.
        for (int i = 0; i < 8; i++) drv_data[i] = 12'($urandom);
        run_scan(8'hFF, 3);

        // Timeout: driver silent.
        drv_mute = 1'b1;
        @(negedge clk);
        trig    = 1'b1;
        ch_mask = 8'h06;
        cnt = 0;
        do begin
            @(negedge clk);
            trig = 1'b0;
            cnt++;
        end while (!adc_wr && cnt < 10);
        chk("tmo_wr_seen", adc_wr, 1);
        chk("tmo_wr_channel", adc_channel, 1);
        cnt   = 0;
        extra = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (adc_wr || scan_done) extra++;
        end while (!timeout_err && cnt < 200);
        chk("tmo_latency", cnt, 64);
        chk("tmo_busy", busy, 0);
        repeat (4) begin
            @(negedge clk);
            if (adc_wr || scan_done || timeout_err) extra++;
        end
        chk("tmo_no_activity", extra, 0);
        drv_mute = 1'b0;
        drv_data[1] = 12'd7;
        drv_data[2] = 12'd4095;
        run_scan(8'h06, -1);

        // Empty mask.
        run_scan(8'h00, -1);

        // Offset written in the rdy cycle of its own channel.
        write_off(3'd3, 12'd10);
        drv_data[3] = 12'd500;
        race_ch  = 3'd3;
        race_val = 12'd300;
        race_en  = 1'b1;
        run_scan(8'h08, -1);
        race_en = 1'b0;
        off_model[3] = 12'd300;
        run_scan(8'h08, -1);

        // Randomized scans.
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 8; i++) begin
                drv_data[i] = 12'($urandom);
                if ($urandom_range(0, 1) == 1) write_off(3'(i), 12'($urandom));
            end
            run_scan(8'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1);
        end

        // Reset in the middle of a conversion.
        for (int i = 0; i < 8; i++) drv_data[i] = 12'($urandom_range(1, 4095));
        run_scan(8'hFF, -1);
        drv_mute = 1'b1;
        @(negedge clk);
        trig    = 1'b1;
        ch_mask = 8'h0F;
        @(negedge clk);
        trig = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mid_busy", busy, 1);
        rstn = 1'b0;
        @(negedge clk);
        check_outputs_zero();
        for (int i = 0; i < 8; i++) begin
            off_model[i] = 12'd0;
            res_model[i] = 13'd0;
        end
        check_bank();
        @(negedge clk);
        rstn     = 1'b1;
        drv_mute = 1'b0;
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (scan_done || adc_wr || busy) extra++;
        end
        chk("rst_no_resume", extra, 0);
        run_scan(8'h0A, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
